// File: rtl/mmu_tile_sched.sv
// Tile scheduler for the MMU_SIZE x MMU_SIZE matrix-multiply unit: feeds K tile pairs and accumulates one C tile.
// Optional build macro MMU_TILE_SCHED_RELU_EN clamps negative result elements to zero.
module mmu_tile_sched #(
  parameter int VAR_SIZE = 8,
  parameter int ACC_SIZE = 32,
  parameter int MMU_SIZE = 4,
  parameter int MMU_LAT  = 2,
  parameter int K_W      = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  logic [K_W-1:0]                         cmd_k,
  input  logic [ACC_SIZE-1:0]                    cmd_bias,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [VAR_SIZE*MMU_SIZE*MMU_SIZE-1:0]  in_a,
  input  logic [VAR_SIZE*MMU_SIZE*MMU_SIZE-1:0]  in_b,
  output logic [VAR_SIZE*MMU_SIZE*MMU_SIZE-1:0]  mmu_a,
  output logic [VAR_SIZE*MMU_SIZE*MMU_SIZE-1:0]  mmu_b,
  output logic [ACC_SIZE-1:0]                    mmu_bias,
  input  logic [ACC_SIZE*MMU_SIZE*MMU_SIZE-1:0]  mmu_c,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [ACC_SIZE*MMU_SIZE*MMU_SIZE-1:0]  out_c,
  output logic                                   busy
);

  localparam int N     = MMU_SIZE * MMU_SIZE;
  localparam int CW    = ACC_SIZE * N;
  localparam int CNT_W = $clog2(MMU_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WAIT = 3'd2,
    S_ACC  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t              state;
  logic [K_W-1:0]      k_rem;
  logic [ACC_SIZE-1:0] bias;
  logic                first;
  logic [CNT_W-1:0]    cnt;
  logic [CW-1:0]       acc;
  logic [CW-1:0]       acc_next;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready depends only on state, and valid/data are held by the sender until that edge.
  assign cmd_ready = (state == S_IDLE);
  assign in_ready  = (state == S_LOAD);
  assign busy      = (state != S_IDLE);

  function automatic logic [CW-1:0] post_proc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = v;
`ifdef MMU_TILE_SCHED_RELU_EN
    for (int i = 0; i < N; i++) begin
      if (v[i*ACC_SIZE + ACC_SIZE - 1]) r[i*ACC_SIZE +: ACC_SIZE] = '0;
    end
`endif
    return r;
  endfunction

  // The first tile overwrites the accumulator so no clear cycle is needed between jobs.
  always_comb begin
    acc_next = '0;
    for (int i = 0; i < N; i++) begin
      acc_next[i*ACC_SIZE +: ACC_SIZE] = (first ? '0 : acc[i*ACC_SIZE +: ACC_SIZE])
                                       + mmu_c[i*ACC_SIZE +: ACC_SIZE];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      k_rem     <= '0;
      bias      <= '0;
      first     <= 1'b0;
      cnt       <= '0;
      mmu_a     <= '0;
      mmu_b     <= '0;
      mmu_bias  <= '0;
      acc       <= '0;
      out_c     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            k_rem <= cmd_k;
            bias  <= cmd_bias;
            first <= 1'b1;
            if (cmd_k == '0) begin
              out_c     <= post_proc({N{cmd_bias}});
              out_valid <= 1'b1;
              state     <= S_OUT;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            mmu_a    <= in_a;
            mmu_b    <= in_b;
            mmu_bias <= first ? bias : '0;
            cnt      <= CNT_W'(MMU_LAT);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= S_ACC;
        end
        S_ACC: begin
          acc   <= acc_next;
          first <= 1'b0;
          k_rem <= k_rem - K_W'(1);
          if (k_rem == K_W'(1)) begin
            out_c     <= post_proc(acc_next);
            out_valid <= 1'b1;
            state     <= S_OUT;
          end else begin
            state <= S_LOAD;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
